mem_access_sequencer: RTL and testbench

Clocked multi-cycle sequencer for SPARC load, store and swap instructions (IR_Out[31:30]=11). It drives the MAR/MDR/RAM/register-file enables and the ALU/mux selects one state per clock, and waits on the RAM MFC handshake. It replaces delay-based sequencing for the format-3 memory family. It raises a fault on illegal opcodes, misaligned addresses or an MFC timeout.

---
 rtl/mem_access_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// -----------------------------------------------------------------------------
// mem_access_sequencer
//
// Multi-cycle control sequencer for the SPARC format-3 memory family (loads,
// stores and swap). Each state lasts at least one clock. The RAM request states
// hold until the RAM raises MFC, or until a bounded wait expires. All datapath
// controls are decoded combinationally from the current state and the latched
// instruction, so every control changes on a clock edge.
//
// Parameters
//   TIMEOUT          cycles allowed in a RAM request state without MFC before
//                    the access is aborted (legal range 1..255)
//
// Ports
//   Clk              system clock, rising edge
//   RESET            synchronous active-high reset
//   start            begin a sequence; only honoured in IDLE
//   IR_Out[31:0]     instruction word; captured on the accepted start edge
//   addr_lsb[1:0]    effective-address bits [1:0] from the ALU, valid in ADDR
//   MFC              memory function complete from the RAM
//   MAR_Enable, MDR_Enable, RAM_enable, register_file, TEMP_Enable
//                    datapath load / access enables
//   MDR_Mux_select   MDR input: 1 = RAM data, 0 = ALU output
//   extender_select  immediate extender mode (00 = simm13)
//   ALUB_Mux_select  ALU B source: 000 PB, 001 extender, 010 MDR, 100 TEMP
//   ALU_op           ALU function, always add
//   in_PA/PB/PC      register file read ports A/B and write port C
//   RAM_OpCode       access size/type presented to the RAM
//   busy             high whenever the sequencer is not idle
//   done             one-cycle pulse on successful completion
//   fault            one-cycle pulse on abort
//   fault_code       01 illegal op, 10 misaligned, 11 MFC timeout; held until
//                    the next accepted start
// -----------------------------------------------------------------------------
module mem_access_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        RESET,
    input  logic        start,
    input  logic [31:0] IR_Out,
    input  logic [1:0]  addr_lsb,
    input  logic        MFC,
    output logic        MAR_Enable,
    output logic        MDR_Enable,
    output logic        RAM_enable,
    output logic        register_file,
    output logic        TEMP_Enable,
    output logic        MDR_Mux_select,
    output logic [1:0]  extender_select,
    output logic [2:0]  ALUB_Mux_select,
    output logic [5:0]  ALU_op,
    output logic [4:0]  in_PA,
    output logic [4:0]  in_PB,
    output logic [4:0]  in_PC,
    output logic [5:0]  RAM_OpCode,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_code
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_RD_REQ,
        S_RD_LATCH,
        S_WB,
        S_SWP_TEMP,
        S_ST_MDR,
        S_WR_REQ,
        S_SWP_WB,
        S_DONE,
        S_FAULT
    } state_t;

    // Last counter value before the wait is declared expired.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    // Opcode classification tables.
    localparam logic [5:0] LOAD_OPS  [5] = '{6'b000000, 6'b000001, 6'b000010,
                                             6'b001001, 6'b001010};
    localparam logic [5:0] STORE_OPS [3] = '{6'b000100, 6'b000101, 6'b000110};
    localparam logic [5:0] WORD_OPS  [3] = '{6'b000000, 6'b000100, 6'b001111};
    localparam logic [5:0] HALF_OPS  [3] = '{6'b000010, 6'b001010, 6'b000110};
    localparam logic [5:0] SWAP_OP        = 6'b001111;

    // RAM opcodes a swap presents for its read and write halves.
    localparam logic [5:0] SWAP_RD_OP     = 6'b000000;
    localparam logic [5:0] SWAP_WR_OP     = 6'b000100;

    state_t      state_reg, state_next;
    logic [31:0] ir_reg, ir_next;
    logic [7:0]  wait_cnt_reg, wait_cnt_next;
    logic [1:0]  fault_code_reg, fault_code_next;

    // Instruction fields, taken from the latched copy.
    logic [4:0]  rd_q, rs1_q, rs2_q;
    logic [5:0]  op3_q;
    logic        imm_q;

    assign rd_q  = ir_reg[29:25];
    assign op3_q = ir_reg[24:19];
    assign rs1_q = ir_reg[18:14];
    assign imm_q = ir_reg[13];
    assign rs2_q = ir_reg[4:0];

    // The format bits and the simm13/asi field are handled elsewhere in the
    // datapath; the sequencer has no use for them.
    logic ir_unused;
    assign ir_unused = ^{ir_reg[31:30], ir_reg[12:5]};

    // In IDLE the instruction is not latched yet, so the legality check on the
    // start edge has to look at IR_Out directly. Every other state uses ir_reg.
    logic [5:0] dec_op3;
    assign dec_op3 = (state_reg == S_IDLE) ? IR_Out[24:19] : op3_q;

    logic [4:0] load_hit;
    logic [2:0] store_hit;
    logic [2:0] word_hit;
    logic [2:0] half_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_load_dec
            assign load_hit[gi] = (dec_op3 == LOAD_OPS[gi]);
        end
        for (gi = 0; gi < 3; gi++) begin : g_class_dec
            assign store_hit[gi] = (dec_op3 == STORE_OPS[gi]);
            assign word_hit[gi]  = (dec_op3 == WORD_OPS[gi]);
            assign half_hit[gi]  = (dec_op3 == HALF_OPS[gi]);
        end
    endgenerate

    logic is_load, is_store, is_swap, op_legal;
    logic is_word, is_half, addr_aligned;
    logic timeout_hit;

    assign is_load  = |load_hit;
    assign is_store = |store_hit;
    assign is_swap  = (dec_op3 == SWAP_OP);
    assign op_legal = is_load | is_store | is_swap;

    assign is_word = |word_hit;
    assign is_half = |half_hit;

    // Byte accesses are never misaligned.
    assign addr_aligned = is_word ? (addr_lsb == 2'b00) :
                          is_half ? (addr_lsb[0] == 1'b0) : 1'b1;

    assign timeout_hit = (wait_cnt_reg == TIMEOUT_LAST);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (RESET) begin
            state_reg      <= S_IDLE;
            ir_reg         <= '0;
            wait_cnt_reg   <= '0;
            fault_code_reg <= '0;
        end else begin
            state_reg      <= state_next;
            ir_reg         <= ir_next;
            wait_cnt_reg   <= wait_cnt_next;
            fault_code_reg <= fault_code_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        fault_code_next = fault_code_reg;
        ir_next         = ir_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    ir_next         = IR_Out;
                    fault_code_next = 2'b00;
                    if (!op_legal) begin
                        state_next      = S_FAULT;
                        fault_code_next = 2'b01;
                    end else begin
                        state_next = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (!addr_aligned) begin
                    state_next      = S_FAULT;
                    fault_code_next = 2'b10;
                end else if (is_store) begin
                    state_next = S_ST_MDR;
                end else begin
                    state_next = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                // A completion arriving on the last allowed cycle still counts.
                if (MFC) begin
                    state_next = S_RD_LATCH;
                end else if (timeout_hit) begin
                    state_next      = S_FAULT;
                    fault_code_next = 2'b11;
                end
            end
            S_RD_LATCH: state_next = is_swap ? S_SWP_TEMP : S_WB;
            S_WB:       state_next = S_DONE;
            S_SWP_TEMP: state_next = S_ST_MDR;
            S_ST_MDR:   state_next = S_WR_REQ;
            S_WR_REQ: begin
                if (MFC) begin
                    state_next = is_swap ? S_SWP_WB : S_DONE;
                end else if (timeout_hit) begin
                    state_next      = S_FAULT;
                    fault_code_next = 2'b11;
                end
            end
            S_SWP_WB:   state_next = S_DONE;
            S_DONE:     state_next = S_IDLE;
            S_FAULT:    state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Wait counter: counts cycles spent in a request state, cleared whenever
    // the state changes so each request starts from zero. Saturates at 255.
    always_comb begin
        wait_cnt_next = '0;
        if ((state_reg == S_RD_REQ || state_reg == S_WR_REQ) &&
            (state_next == state_reg)) begin
            wait_cnt_next = (wait_cnt_reg == 8'hFF) ? wait_cnt_reg
                                                    : wait_cnt_reg + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Output logic (Moore, from the current state)
    // -------------------------------------------------------------------------
    always_comb begin
        MAR_Enable      = 1'b0;
        MDR_Enable      = 1'b0;
        RAM_enable      = 1'b0;
        register_file   = 1'b0;
        TEMP_Enable     = 1'b0;
        MDR_Mux_select  = 1'b0;
        extender_select = 2'b00;
        ALUB_Mux_select = 3'b000;
        in_PA           = 5'd0;
        in_PB           = 5'd0;
        in_PC           = 5'd0;
        RAM_OpCode      = 6'b000000;
        done            = 1'b0;
        fault           = 1'b0;

        case (state_reg)
            S_ADDR: begin
                // Effective address rs1 + (simm13 | rs2) goes into MAR.
                MAR_Enable = 1'b1;
                in_PA      = rs1_q;
                if (imm_q) begin
                    ALUB_Mux_select = 3'b001;
                    extender_select = 2'b00;
                end else begin
                    ALUB_Mux_select = 3'b000;
                    in_PB           = rs2_q;
                end
            end
            S_RD_REQ: begin
                RAM_enable     = 1'b1;
                MDR_Mux_select = 1'b1;
                RAM_OpCode     = is_swap ? SWAP_RD_OP : op3_q;
            end
            S_RD_LATCH: begin
                RAM_enable     = 1'b1;
                MDR_Mux_select = 1'b1;
                MDR_Enable     = 1'b1;
            end
            S_WB: begin
                // rd <= r0 + MDR; a write to r0 is discarded by the register file.
                register_file   = 1'b1;
                in_PC           = rd_q;
                in_PA           = 5'd0;
                ALUB_Mux_select = 3'b010;
            end
            S_SWP_TEMP: begin
                // Park the loaded word in TEMP before MDR is overwritten.
                TEMP_Enable     = 1'b1;
                ALUB_Mux_select = 3'b010;
                in_PA           = 5'd0;
            end
            S_ST_MDR: begin
                // MDR <= rd + r0, the store data.
                in_PA           = rd_q;
                in_PB           = 5'd0;
                ALUB_Mux_select = 3'b000;
                MDR_Mux_select  = 1'b0;
                MDR_Enable      = 1'b1;
            end
            S_WR_REQ: begin
                RAM_enable = 1'b1;
                RAM_OpCode = is_swap ? SWAP_WR_OP : op3_q;
            end
            S_SWP_WB: begin
                // rd <= r0 + TEMP, the old memory word.
                register_file   = 1'b1;
                in_PC           = rd_q;
                in_PA           = 5'd0;
                ALUB_Mux_select = 3'b100;
            end
            S_DONE:  done  = 1'b1;
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

    assign ALU_op     = 6'b000000;
    assign busy       = (state_reg != S_IDLE);
    assign fault_code = fault_code_reg;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for mem_access_sequencer. Each scenario task
// walks a sequence cycle by cycle and compares the full control word against a
// hand-written expected value for that cycle.
// -----------------------------------------------------------------------------
module tb_mem_access_sequencer;

    localparam int TIMEOUT = 4;
    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    logic        Clk = 1'b0;
    logic        RESET;
    logic        start;
    logic [31:0] IR_Out;
    logic [1:0]  addr_lsb;
    logic        MFC;

    logic        MAR_Enable, MDR_Enable, RAM_enable, register_file, TEMP_Enable;
    logic        MDR_Mux_select;
    logic [1:0]  extender_select;
    logic [2:0]  ALUB_Mux_select;
    logic [5:0]  ALU_op;
    logic [4:0]  in_PA, in_PB, in_PC;
    logic [5:0]  RAM_OpCode;
    logic        busy, done, fault;
    logic [1:0]  fault_code;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 Clk = ~Clk;

    mem_access_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .Clk             (Clk),
        .RESET           (RESET),
        .start           (start),
        .IR_Out          (IR_Out),
        .addr_lsb        (addr_lsb),
        .MFC             (MFC),
        .MAR_Enable      (MAR_Enable),
        .MDR_Enable      (MDR_Enable),
        .RAM_enable      (RAM_enable),
        .register_file   (register_file),
        .TEMP_Enable     (TEMP_Enable),
        .MDR_Mux_select  (MDR_Mux_select),
        .extender_select (extender_select),
        .ALUB_Mux_select (ALUB_Mux_select),
        .ALU_op          (ALU_op),
        .in_PA           (in_PA),
        .in_PB           (in_PB),
        .in_PC           (in_PC),
        .RAM_OpCode      (RAM_OpCode),
        .busy            (busy),
        .done            (done),
        .fault           (fault),
        .fault_code      (fault_code)
    );

    // Observed control word:
    // {mar, mdr, ram, rf, temp, mdrmux, ext[2], alub[3], aluop[6],
    //  pa[5], pb[5], pc[5], ramop[6], busy, done, fault, fcode[2]}
    logic [42:0] obs;
    assign obs = {MAR_Enable, MDR_Enable, RAM_enable, register_file, TEMP_Enable,
                  MDR_Mux_select, extender_select, ALUB_Mux_select, ALU_op,
                  in_PA, in_PB, in_PC, RAM_OpCode, busy, done, fault, fault_code};

    // Builds an expected control word; ALU_op is always add (000000).
    function automatic logic [42:0] pk(
        input logic mar, input logic mdr, input logic ram, input logic rf,
        input logic tmp, input logic mux, input logic [1:0] ext,
        input logic [2:0] alub, input logic [4:0] pa, input logic [4:0] pb,
        input logic [4:0] pc, input logic [5:0] rop, input logic bsy,
        input logic dn, input logic flt, input logic [1:0] fc);
        return {mar, mdr, ram, rf, tmp, mux, ext, alub, 6'b000000,
                pa, pb, pc, rop, bsy, dn, flt, fc};
    endfunction

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        logic [42:0] exp;
        exp = '0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) RESET = 1'b0;
            step();
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL reset cycle %0d: got %h expected %h", c, obs, exp);
            end
        end
    endtask

    // ld [r1+4], r1 with MFC arriving on the third RD_REQ cycle.
    task automatic test_load_word();
        logic [42:0] exp;
        IR_Out = 32'hC2006004; addr_lsb = 2'b00; MFC = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            case (c)
                1:       exp = pk(Y,N,N,N,N,N,2'b00,3'b001,5'd1,5'd0,5'd0,6'd0,Y,N,N,2'b00);
                2, 3, 4: exp = pk(N,N,Y,N,N,Y,2'b00,3'b000,5'd0,5'd0,5'd0,6'd0,Y,N,N,2'b00);
                5:       exp = pk(N,Y,Y,N,N,Y,2'b00,3'b000,5'd0,5'd0,5'd0,6'd0,Y,N,N,2'b00);
                6:       exp = pk(N,N,N,Y,N,N,2'b00,3'b010,5'd0,5'd0,5'd1,6'd0,Y,N,N,2'b00);
                7:       exp = pk(N,N,N,N,N,N,2'b00,3'b000,5'd0,5'd0,5'd0,6'd0,Y,Y,N,2'b00);
                default: exp = '0;
            endcase
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL load_word cycle %0d: got %h expected %h", c, obs, exp);
            end
            MFC = (c == 4);
            step();
        end
        MFC = 1'b0;
    endtask

    // sth r3, [r4+r2], address ending in 10.
    task automatic test_store_half();
        logic [42:0] exp;
        IR_Out = {2'b11, 5'd3, 6'b000110, 5'd4, 1'b0, 8'd0, 5'd2};
        addr_lsb = 2'b10; MFC = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            case (c)
                1:       exp = pk(Y,N,N,N,N,N,2'b00,3'b000,5'd4,5'd2,5'd0,6'd0,Y,N,N,2'b00);
                2:       exp = pk(N,Y,N,N,N,N,2'b00,3'b000,5'd3,5'd0,5'd0,6'd0,Y,N,N,2'b00);
                3:       exp = pk(N,N,Y,N,N,N,2'b00,3'b000,5'd0,5'd0,5'd0,6'b000110,Y,N,N,2'b00);
                4:       exp = pk(N,N,N,N,N,N,2'b00,3'b000,5'd0,5'd0,5'd0,6'd0,Y,Y,N,2'b00);
                default: exp = '0;
            endcase
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL store_half cycle %0d: got %h expected %h", c, obs, exp);
            end
            MFC = (c == 3);
            step();
        end
        MFC = 1'b0;
    endtask

    // swap [r2+0], r5 with immediate MFC on both requests.
    task automatic test_swap();
        logic [42:0] exp;
        IR_Out = {2'b11, 5'd5, 6'b001111, 5'd2, 1'b1, 13'd0};
        addr_lsb = 2'b00; MFC = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            case (c)
                1:       exp = pk(Y,N,N,N,N,N,2'b00,3'b001,5'd2,5'd0,5'd0,6'd0,Y,N,N,2'b00);
                2:       exp = pk(N,N,Y,N,N,Y,2'b00,3'b000,5'd0,5'd0,5'd0,6'b000000,Y,N,N,2'b00);
                3:       exp = pk(N,Y,Y,N,N,Y,2'b00,3'b000,5'd0,5'd0,5'd0,6'd0,Y,N,N,2'b00);
                4:       exp = pk(N,N,N,N,Y,N,2'b00,3'b010,5'd0,5'd0,5'd0,6'd0,Y,N,N,2'b00);
                5:       exp = pk(N,Y,N,N,N,N,2'b00,3'b000,5'd5,5'd0,5'd0,6'd0,Y,N,N,2'b00);
                6:       exp = pk(N,N,Y,N,N,N,2'b00,3'b000,5'd0,5'd0,5'd0,6'b000100,Y,N,N,2'b00);
                7:       exp = pk(N,N,N,Y,N,N,2'b00,3'b100,5'd0,5'd0,5'd5,6'd0,Y,N,N,2'b00);
                8:       exp = pk(N,N,N,N,N,N,2'b00,3'b000,5'd0,5'd0,5'd0,6'd0,Y,Y,N,2'b00);
                default: exp = '0;
            endcase
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL swap cycle %0d: got %h expected %h", c, obs, exp);
            end
            MFC = (c == 2) || (c == 6);
            step();
        end
        MFC = 1'b0;
    endtask

    // ldd (000011) is illegal: fault on the first cycle, no MAR load.
    task automatic test_illegal_op();
        logic [42:0] exp;
        IR_Out = {2'b11, 5'd1, 6'b000011, 5'd1, 1'b1, 13'd0};
        addr_lsb = 2'b00; MFC = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            case (c)
                1:       exp = pk(N,N,N,N,N,N,2'b00,3'b000,5'd0,5'd0,5'd0,6'd0,Y,N,Y,2'b01);
                default: exp = pk(N,N,N,N,N,N,2'b00,3'b000,5'd0,5'd0,5'd0,6'd0,N,N,N,2'b01);
            endcase
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL illegal_op cycle %0d: got %h expected %h", c, obs, exp);
            end
            step();
        end
    endtask

    // ld with address ending in 10: fault after ADDR, code cleared on start.
    task automatic test_misaligned();
        logic [42:0] exp;
        IR_Out = 32'hC2006004; addr_lsb = 2'b10; MFC = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            case (c)
                1:       exp = pk(Y,N,N,N,N,N,2'b00,3'b001,5'd1,5'd0,5'd0,6'd0,Y,N,N,2'b00);
                2:       exp = pk(N,N,N,N,N,N,2'b00,3'b000,5'd0,5'd0,5'd0,6'd0,Y,N,Y,2'b10);
                default: exp = pk(N,N,N,N,N,N,2'b00,3'b000,5'd0,5'd0,5'd0,6'd0,N,N,N,2'b10);
            endcase
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL misaligned cycle %0d: got %h expected %h", c, obs, exp);
            end
            step();
        end
    endtask

    // TIMEOUT=4 with MFC never arriving.
    task automatic test_timeout();
        logic [42:0] exp;
        IR_Out = 32'hC2006004; addr_lsb = 2'b00; MFC = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            case (c)
                1:          exp = pk(Y,N,N,N,N,N,2'b00,3'b001,5'd1,5'd0,5'd0,6'd0,Y,N,N,2'b00);
                2, 3, 4, 5: exp = pk(N,N,Y,N,N,Y,2'b00,3'b000,5'd0,5'd0,5'd0,6'd0,Y,N,N,2'b00);
                6:          exp = pk(N,N,N,N,N,N,2'b00,3'b000,5'd0,5'd0,5'd0,6'd0,Y,N,Y,2'b11);
                default:    exp = pk(N,N,N,N,N,N,2'b00,3'b000,5'd0,5'd0,5'd0,6'd0,N,N,N,2'b11);
            endcase
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL timeout cycle %0d: got %h expected %h", c, obs, exp);
            end
            step();
        end
    endtask

    // MFC on the very cycle the wait would expire: completion wins.
    task automatic test_mfc_at_timeout();
        logic [42:0] exp;
        IR_Out = 32'hC2006004; addr_lsb = 2'b00; MFC = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            case (c)
                1:          exp = pk(Y,N,N,N,N,N,2'b00,3'b001,5'd1,5'd0,5'd0,6'd0,Y,N,N,2'b00);
                2, 3, 4, 5: exp = pk(N,N,Y,N,N,Y,2'b00,3'b000,5'd0,5'd0,5'd0,6'd0,Y,N,N,2'b00);
                6:          exp = pk(N,Y,Y,N,N,Y,2'b00,3'b000,5'd0,5'd0,5'd0,6'd0,Y,N,N,2'b00);
                7:          exp = pk(N,N,N,Y,N,N,2'b00,3'b010,5'd0,5'd0,5'd1,6'd0,Y,N,N,2'b00);
                8:          exp = pk(N,N,N,N,N,N,2'b00,3'b000,5'd0,5'd0,5'd0,6'd0,Y,Y,N,2'b00);
                default:    exp = '0;
            endcase
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL mfc_at_timeout cycle %0d: got %h expected %h", c, obs, exp);
            end
            MFC = (c == 5);
            step();
        end
        MFC = 1'b0;
    endtask

    // ldub at address ..11 (unchecked), then straight into an ldsh at ..01
    // (halfword misaligned) started in the idle cycle after done.
    task automatic test_back_to_back();
        logic [42:0] exp;
        IR_Out = {2'b11, 5'd2, 6'b000001, 5'd3, 1'b0, 8'd0, 5'd4};
        addr_lsb = 2'b11; MFC = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            case (c)
                1:       exp = pk(Y,N,N,N,N,N,2'b00,3'b000,5'd3,5'd4,5'd0,6'd0,Y,N,N,2'b00);
                2:       exp = pk(N,N,Y,N,N,Y,2'b00,3'b000,5'd0,5'd0,5'd0,6'b000001,Y,N,N,2'b00);
                3:       exp = pk(N,Y,Y,N,N,Y,2'b00,3'b000,5'd0,5'd0,5'd0,6'd0,Y,N,N,2'b00);
                4:       exp = pk(N,N,N,Y,N,N,2'b00,3'b010,5'd0,5'd0,5'd2,6'd0,Y,N,N,2'b00);
                5:       exp = pk(N,N,N,N,N,N,2'b00,3'b000,5'd0,5'd0,5'd0,6'd0,Y,Y,N,2'b00);
                6:       exp = '0;
                7:       exp = pk(Y,N,N,N,N,N,2'b00,3'b001,5'd0,5'd0,5'd0,6'd0,Y,N,N,2'b00);
                8:       exp = pk(N,N,N,N,N,N,2'b00,3'b000,5'd0,5'd0,5'd0,6'd0,Y,N,Y,2'b10);
                default: exp = pk(N,N,N,N,N,N,2'b00,3'b000,5'd0,5'd0,5'd0,6'd0,N,N,N,2'b10);
            endcase
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL back_to_back cycle %0d: got %h expected %h", c, obs, exp);
            end
            MFC = (c == 2);
            if (c == 6) begin
                start    = 1'b1;
                IR_Out   = {2'b11, 5'd6, 6'b001010, 5'd0, 1'b1, 13'd2};
                addr_lsb = 2'b01;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
    endtask

    // st r7,[r1+8] stalled in WR_REQ; a start while busy is ignored, then
    // RESET aborts silently; a fresh stb afterwards runs normally.
    task automatic test_reset_mid_op();
        logic [42:0] exp;
        IR_Out = {2'b11, 5'd7, 6'b000100, 5'd1, 1'b1, 13'd8};
        addr_lsb = 2'b00; MFC = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            case (c)
                1:       exp = pk(Y,N,N,N,N,N,2'b00,3'b001,5'd1,5'd0,5'd0,6'd0,Y,N,N,2'b00);
                2:       exp = pk(N,Y,N,N,N,N,2'b00,3'b000,5'd7,5'd0,5'd0,6'd0,Y,N,N,2'b00);
                3:       exp = pk(N,N,Y,N,N,N,2'b00,3'b000,5'd0,5'd0,5'd0,6'b000100,Y,N,N,2'b00);
                default: exp = '0;
            endcase
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL reset_mid_op cycle %0d: got %h expected %h", c, obs, exp);
            end
            start = (c == 2);
            if (c == 2) IR_Out = {2'b11, 5'd9, 6'b000101, 5'd2, 1'b1, 13'd3};
            RESET = (c == 3);
            step();
        end
        start = 1'b0;
        RESET = 1'b0;
    endtask

    task automatic test_after_reset();
        logic [42:0] exp;
        IR_Out = {2'b11, 5'd9, 6'b000101, 5'd2, 1'b1, 13'd3};
        addr_lsb = 2'b11; MFC = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            case (c)
                1:       exp = pk(Y,N,N,N,N,N,2'b00,3'b001,5'd2,5'd0,5'd0,6'd0,Y,N,N,2'b00);
                2:       exp = pk(N,Y,N,N,N,N,2'b00,3'b000,5'd9,5'd0,5'd0,6'd0,Y,N,N,2'b00);
                3:       exp = pk(N,N,Y,N,N,N,2'b00,3'b000,5'd0,5'd0,5'd0,6'b000101,Y,N,N,2'b00);
                4:       exp = pk(N,N,N,N,N,N,2'b00,3'b000,5'd0,5'd0,5'd0,6'd0,Y,Y,N,2'b00);
                default: exp = '0;
            endcase
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL after_reset cycle %0d: got %h expected %h", c, obs, exp);
            end
            MFC = (c == 3);
            step();
        end
        MFC = 1'b0;
    endtask

    initial begin
        RESET    = 1'b1;
        start    = 1'b0;
        IR_Out   = 32'd0;
        addr_lsb = 2'b00;
        MFC      = 1'b0;

        test_reset();
        test_load_word();
        test_store_half();
        test_swap();
        test_illegal_op();
        test_misaligned();
        test_timeout();
        test_mfc_at_timeout();
        test_back_to_back();
        test_reset_mid_op();
        test_after_reset();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
